nano_dbg_spi_slave: RTL and testbench

- SPI debug slave inside the NanoController top level. It is the responder for the testbench SPI debug master.
- Decodes 32-bit SPI frames into IMEM write/read accesses, a core run/hold control and a status readback.
- Runs entirely on the Nano clock. SCLK/MOSI/EN_N are synchronized and edge-detected; no SCLK clock domain exists.
- Drives the boot-time instruction-memory port and the core run gate.

---
 rtl/nano_dbg_spi_slave_pkg.sv | 34 +++
 rtl/nano_dbg_spi_slave_if.sv | 27 ++
 rtl/nano_dbg_spi_sync.sv | 49 ++++
 rtl/nano_dbg_spi_slave.sv | 169 ++++++++++++++++
 tb/tb_nano_dbg_spi_slave.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/nano_dbg_spi_slave_pkg.sv
// rtl/nano_dbg_spi_slave_pkg.sv - shared constants and types for the Nano SPI debug slave
// Contents: widths, frame length, command codes, FSM state type, command helper.
package nano_dbg_pkg;

    localparam int NANO_I_W_C     = 4;
    localparam int NANO_I_ADR_W_C = 9;
    localparam int SYNC_STAGES_C  = 2;
    localparam int FRAME_BITS_C   = 32;

    localparam logic [7:0] CMD_WRITE_C  = 8'h01;
    localparam logic [7:0] CMD_READ_C   = 8'h02;
    localparam logic [7:0] CMD_RUN_C    = 8'h03;
    localparam logic [7:0] CMD_STATUS_C = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_EXEC,
        ST_WAIT_DESEL
    } dbg_state_e;

    function automatic logic cmd_known(input logic [7:0] cmd);
        return (cmd == CMD_WRITE_C) || (cmd == CMD_READ_C) ||
               (cmd == CMD_RUN_C)   || (cmd == CMD_STATUS_C);
    endfunction

    // Commands whose DATA phase carries a byte back to the host on MISO.
    function automatic logic cmd_returns_data(input logic [7:0] cmd);
        return (cmd == CMD_READ_C) || (cmd == CMD_STATUS_C);
    endfunction

endpackage

// File: rtl/nano_dbg_spi_slave_if.sv
// rtl/nano_dbg_spi_slave_if.sv - SPI pins plus boot IMEM port of the debug slave
// slave modport: SPI en_n/sclk/mosi and IMEM rdata in; MISO, IMEM we/re/addr/wdata out.
// master modport: the mirror image, used by the host side / IMEM owner.
interface nano_dbg_spi_slave_if #(
    parameter int NANO_I_W_C     = 4,
    parameter int NANO_I_ADR_W_C = 9
);
    logic                      i_dbg_spi_en_n;
    logic                      i_dbg_spi_sclk;
    logic                      i_dbg_spi_mosi;
    logic                      o_dbg_spi_miso;
    logic                      o_imem_we;
    logic                      o_imem_re;
    logic [NANO_I_ADR_W_C-1:0] o_imem_addr;
    logic [NANO_I_W_C-1:0]     o_imem_wdata;
    logic [NANO_I_W_C-1:0]     i_imem_rdata;

    modport slave (
        input  i_dbg_spi_en_n, i_dbg_spi_sclk, i_dbg_spi_mosi, i_imem_rdata,
        output o_dbg_spi_miso, o_imem_we, o_imem_re, o_imem_addr, o_imem_wdata
    );

    modport master (
        output i_dbg_spi_en_n, i_dbg_spi_sclk, i_dbg_spi_mosi, i_imem_rdata,
        input  o_dbg_spi_miso, o_imem_we, o_imem_re, o_imem_addr, o_imem_wdata
    );
endinterface

// File: rtl/nano_dbg_spi_sync.sv
// rtl/nano_dbg_spi_sync.sv - synchronizer and edge detector for SPI en_n/sclk/mosi
// Ports: clk, rst_n (async, active low), raw en_n/sclk/mosi in;
//        synchronized en_n_s/mosi_s, one-cycle sclk_rise/sclk_fall/en_fall/en_rise out.
module nano_dbg_spi_sync #(
    parameter int SYNC_STAGES_C = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_n,
    input  logic sclk,
    input  logic mosi,
    output logic en_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic en_fall,
    output logic en_rise
);
    logic [SYNC_STAGES_C-1:0] en_q;
    logic [SYNC_STAGES_C-1:0] sclk_q;
    logic [SYNC_STAGES_C-1:0] mosi_q;
    logic                     en_d;
    logic                     sclk_d;

    // Everything resets to 0, so a chip select already low at reset release
    // produces no falling edge and the slave keeps waiting for a fresh frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q   <= '0;
            sclk_q <= '0;
            mosi_q <= '0;
            en_d   <= 1'b0;
            sclk_d <= 1'b0;
        end else begin
            en_q   <= {en_q[SYNC_STAGES_C-2:0], en_n};
            sclk_q <= {sclk_q[SYNC_STAGES_C-2:0], sclk};
            mosi_q <= {mosi_q[SYNC_STAGES_C-2:0], mosi};
            en_d   <= en_q[SYNC_STAGES_C-1];
            sclk_d <= sclk_q[SYNC_STAGES_C-1];
        end
    end

    assign en_n_s    = en_q[SYNC_STAGES_C-1];
    assign mosi_s    = mosi_q[SYNC_STAGES_C-1];
    assign sclk_rise =  sclk_q[SYNC_STAGES_C-1] & ~sclk_d;
    assign sclk_fall = ~sclk_q[SYNC_STAGES_C-1] &  sclk_d;
    assign en_fall   = ~en_q[SYNC_STAGES_C-1]   &  en_d;
    assign en_rise   =  en_q[SYNC_STAGES_C-1]   & ~en_d;
endmodule

// File: rtl/nano_dbg_spi_slave.sv
// rtl/nano_dbg_spi_slave.sv - SPI debug slave: 32-bit frames to IMEM write/read, run gate, status
// Ports: i_nano_clk, i_nano_rst_n (async, active low); dbg (slave modport: SPI pins, IMEM port);
//        o_core_run (1 = core released), o_dbg_err (sticky protocol error).
module nano_dbg_spi_slave
    import nano_dbg_pkg::*;
#(
    parameter int NANO_I_W_C     = nano_dbg_pkg::NANO_I_W_C,
    parameter int NANO_I_ADR_W_C = nano_dbg_pkg::NANO_I_ADR_W_C,
    parameter int SYNC_STAGES_C  = nano_dbg_pkg::SYNC_STAGES_C
) (
    input  logic                 i_nano_clk,
    input  logic                 i_nano_rst_n,
    nano_dbg_spi_slave_if.slave  dbg,
    output logic                 o_core_run,
    output logic                 o_dbg_err
);
    logic en_n_s, mosi_s, sclk_rise, sclk_fall, en_fall, en_rise;

    nano_dbg_spi_sync #(.SYNC_STAGES_C(SYNC_STAGES_C)) u_sync (
        .clk       (i_nano_clk),
        .rst_n     (i_nano_rst_n),
        .en_n      (dbg.i_dbg_spi_en_n),
        .sclk      (dbg.i_dbg_spi_sclk),
        .mosi      (dbg.i_dbg_spi_mosi),
        .en_n_s    (en_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .en_fall   (en_fall),
        .en_rise   (en_rise)
    );

    dbg_state_e                state;
    logic [5:0]                bit_cnt;
    logic [15:0]               rx_sr;
    logic [7:0]                cmd_q;
    logic [15:0]               addr_q;
    logic [NANO_I_W_C-1:0]     data_q;
    logic [7:0]                tx_sr;
    logic                      rd_cap;

    // Field values as they complete on the current rise (shift register plus incoming bit).
    logic [7:0]  byte_nxt;
    logic [15:0] addr_nxt;
    logic        addr_nxt_ok;
    logic        addr_q_ok;

    assign byte_nxt    = {rx_sr[6:0], mosi_s};
    assign addr_nxt    = {rx_sr[14:0], mosi_s};
    assign addr_nxt_ok = (addr_nxt[15:NANO_I_ADR_W_C] == '0);
    assign addr_q_ok   = (addr_q[15:NANO_I_ADR_W_C] == '0);

    always_ff @(posedge i_nano_clk or negedge i_nano_rst_n) begin
        if (!i_nano_rst_n) begin
            state              <= ST_IDLE;
            bit_cnt            <= '0;
            rx_sr              <= '0;
            cmd_q              <= '0;
            addr_q             <= '0;
            data_q             <= '0;
            tx_sr              <= '0;
            rd_cap             <= 1'b0;
            o_core_run         <= 1'b0;
            o_dbg_err          <= 1'b0;
            dbg.o_dbg_spi_miso <= 1'b0;
            dbg.o_imem_we      <= 1'b0;
            dbg.o_imem_re      <= 1'b0;
            dbg.o_imem_addr    <= '0;
            dbg.o_imem_wdata   <= '0;
        end else begin
            dbg.o_imem_we <= 1'b0;
            dbg.o_imem_re <= 1'b0;
            // IMEM answers one cycle after the read strobe; grab it then.
            rd_cap        <= dbg.o_imem_re;
            if (rd_cap) begin
                tx_sr <= 8'(dbg.i_imem_rdata);
            end

            if (sclk_rise) begin
                rx_sr <= addr_nxt;
            end

            case (state)
                ST_IDLE: begin
                    dbg.o_dbg_spi_miso <= 1'b0;
                    if (en_fall) begin
                        state   <= ST_CMD;
                        bit_cnt <= '0;
                    end
                end

                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (en_rise) begin
                        // Aborted frame: nothing committed, error flag untouched.
                        state              <= ST_IDLE;
                        dbg.o_dbg_spi_miso <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            bit_cnt <= bit_cnt + 6'd1;
                        end
                        if (state == ST_CMD && sclk_rise && bit_cnt == 6'd7) begin
                            cmd_q <= byte_nxt;
                            if (cmd_known(byte_nxt)) begin
                                state <= ST_ADDR;
                            end else begin
                                o_dbg_err <= 1'b1;
                                state     <= ST_WAIT_DESEL;
                            end
                        end
                        if (state == ST_ADDR && sclk_rise && bit_cnt == 6'd23) begin
                            addr_q <= addr_nxt;
                            state  <= ST_DATA;
                            if (cmd_q == CMD_READ_C) begin
                                if (addr_nxt_ok) begin
                                    dbg.o_imem_re   <= 1'b1;
                                    dbg.o_imem_addr <= addr_nxt[NANO_I_ADR_W_C-1:0];
                                end else begin
                                    o_dbg_err <= 1'b1;
                                    tx_sr     <= '0;
                                end
                            end else if (cmd_q == CMD_STATUS_C) begin
                                tx_sr <= {o_core_run, o_dbg_err, 6'b0};
                            end
                        end
                        if (state == ST_DATA) begin
                            if (sclk_rise && bit_cnt == 6'd31) begin
                                data_q             <= byte_nxt[NANO_I_W_C-1:0];
                                state              <= ST_EXEC;
                                dbg.o_dbg_spi_miso <= 1'b0;
                            end else if (sclk_fall && cmd_returns_data(cmd_q)) begin
                                dbg.o_dbg_spi_miso <= tx_sr[7];
                                tx_sr              <= {tx_sr[6:0], 1'b0};
                            end
                        end
                    end
                end

                ST_EXEC: begin
                    dbg.o_dbg_spi_miso <= 1'b0;
                    state              <= ST_WAIT_DESEL;
                    case (cmd_q)
                        CMD_WRITE_C: begin
                            if (addr_q_ok) begin
                                dbg.o_imem_we    <= 1'b1;
                                dbg.o_imem_addr  <= addr_q[NANO_I_ADR_W_C-1:0];
                                dbg.o_imem_wdata <= data_q;
                            end else begin
                                o_dbg_err <= 1'b1;
                            end
                        end
                        CMD_RUN_C:    o_core_run <= data_q[0];
                        // The status byte has already left on MISO, so clearing now is safe.
                        CMD_STATUS_C: o_dbg_err  <= 1'b0;
                        default:      ;
                    endcase
                end

                ST_WAIT_DESEL: begin
                    dbg.o_dbg_spi_miso <= 1'b0;
                    if (en_n_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nano_dbg_spi_slave.sv
// tb/tb_nano_dbg_spi_slave.sv - self-checking bench for nano_dbg_spi_slave
module tb_nano_dbg_spi_slave;
    import nano_dbg_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic core_run, dbg_err;
    always #5 clk = ~clk;

    nano_dbg_spi_slave_if #(.NANO_I_W_C(4), .NANO_I_ADR_W_C(9)) dbg_if ();

    nano_dbg_spi_slave dut (
        .i_nano_clk   (clk),
        .i_nano_rst_n (rst_n),
        .dbg          (dbg_if.slave),
        .o_core_run   (core_run),
        .o_dbg_err    (dbg_err)
    );

    // IMEM environment: registered read, synchronous write.
    logic [3:0] imem [512];
    always @(posedge clk) begin
        if (dbg_if.o_imem_re) dbg_if.i_imem_rdata <= imem[dbg_if.o_imem_addr];
        if (dbg_if.o_imem_we) imem[dbg_if.o_imem_addr] <= dbg_if.o_imem_wdata;
    end

    // Strobe monitor.
    int         we_cnt, re_cnt;
    logic [8:0] we_addr, re_addr;
    logic [3:0] we_data;
    always @(negedge clk) begin
        if (dbg_if.o_imem_we) begin
            we_cnt  = we_cnt + 1;
            we_addr = dbg_if.o_imem_addr;
            we_data = dbg_if.o_imem_wdata;
        end
        if (dbg_if.o_imem_re) begin
            re_cnt  = re_cnt + 1;
            re_addr = dbg_if.o_imem_addr;
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state.
    logic       m_run = 1'b0;
    logic       m_err = 1'b0;
    logic [3:0] m_mem [512];

    // Host side: nbits rises then deselect; collects MISO seen before rises 25..32.
    task automatic spi_frame(input logic [31:0] f, input int nbits,
                             output logic [7:0] rx, output logic early);
        rx = '0;
        early = 1'b0;
        @(negedge clk);
        dbg_if.i_dbg_spi_en_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            dbg_if.i_dbg_spi_mosi = f[31-i];
            repeat (5) @(negedge clk);
            if (i >= 24) rx = {rx[6:0], dbg_if.o_dbg_spi_miso};
            else         early = early | dbg_if.o_dbg_spi_miso;
            dbg_if.i_dbg_spi_sclk = 1'b1;
            repeat (5) @(negedge clk);
            dbg_if.i_dbg_spi_sclk = 1'b0;
        end
        repeat (5) @(negedge clk);
        dbg_if.i_dbg_spi_en_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr,
                             input logic [7:0] data, input int nbits);
        logic [7:0] rx, exp_rx;
        logic       early, exp_we, exp_re, known, in_range;
        string      t;
        exp_we = 0; exp_re = 0; exp_rx = 8'h00;
        known    = (cmd >= 8'h01 && cmd <= 8'h04);
        in_range = (addr < 16'd512);
        if (nbits >= 8 && !known) m_err = 1'b1;
        else if (known) begin
            case (cmd)
                8'h01: if (nbits == 32) begin
                    if (in_range) begin exp_we = 1; m_mem[addr[8:0]] = data[3:0]; end
                    else m_err = 1'b1;
                end
                8'h02: if (nbits >= 24) begin
                    if (in_range) begin exp_re = 1; exp_rx = {4'h0, m_mem[addr[8:0]]}; end
                    else m_err = 1'b1;
                end
                8'h03: if (nbits == 32) m_run = data[0];
                default: begin
                    if (nbits >= 24) exp_rx = {m_run, m_err, 6'b0};
                    if (nbits == 32) m_err = 1'b0;
                end
            endcase
        end
        we_cnt = 0; re_cnt = 0;
        spi_frame({cmd, addr, data}, nbits, rx, early);
        t = $sformatf("c%02h_a%04h_d%02h_n%0d", cmd, addr, data, nbits);
        check({t, " we_cnt"}, we_cnt, {31'b0, exp_we});
        check({t, " re_cnt"}, re_cnt, {31'b0, exp_re});
        if (exp_we) begin
            check({t, " we_addr"}, {23'b0, we_addr}, {23'b0, addr[8:0]});
            check({t, " we_data"}, {28'b0, we_data}, {28'b0, data[3:0]});
        end
        if (exp_re) check({t, " re_addr"}, {23'b0, re_addr}, {23'b0, addr[8:0]});
        if (nbits == 32) check({t, " miso_byte"}, {24'b0, rx}, {24'b0, exp_rx});
        check({t, " miso_early"}, {31'b0, early}, 32'd0);
        check({t, " core_run"}, {31'b0, core_run}, {31'b0, m_run});
        check({t, " dbg_err"}, {31'b0, dbg_err}, {31'b0, m_err});
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  c;
        logic [15:0] a;
        int          n;
        dbg_if.i_dbg_spi_en_n = 1'b1;
        dbg_if.i_dbg_spi_sclk = 1'b0;
        dbg_if.i_dbg_spi_mosi = 1'b0;
        we_cnt = 0; re_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            imem[i]  = 4'($urandom);
            m_mem[i] = imem[i];
        end
        imem[9'h1FF]  = 4'h7;
        m_mem[9'h1FF] = 4'h7;

        repeat (4) @(negedge clk);
        check("rst miso",  {31'b0, dbg_if.o_dbg_spi_miso}, 32'd0);
        check("rst we",    {31'b0, dbg_if.o_imem_we}, 32'd0);
        check("rst re",    {31'b0, dbg_if.o_imem_re}, 32'd0);
        check("rst addr",  {23'b0, dbg_if.o_imem_addr}, 32'd0);
        check("rst wdata", {28'b0, dbg_if.o_imem_wdata}, 32'd0);
        check("rst run",   {31'b0, core_run}, 32'd0);
        check("rst err",   {31'b0, dbg_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst we", {31'b0, dbg_if.o_imem_we}, 32'd0);

        run_frame(8'h01, 16'h0005, 8'h0A, 32);
        run_frame(8'h02, 16'h01FF, 8'h00, 32);
        run_frame(8'h02, 16'h0005, 8'h00, 32);
        run_frame(8'h03, 16'h0000, 8'h01, 32);
        run_frame(8'h03, 16'h0000, 8'h00, 32);
        run_frame(8'h7E, 16'h0000, 8'h00, 32);
        run_frame(8'h04, 16'h0000, 8'h00, 32);
        run_frame(8'h04, 16'h0000, 8'h00, 32);
        run_frame(8'h01, 16'h0200, 8'h03, 32);
        run_frame(8'h01, 16'h0003, 8'h05, 20);
        run_frame(8'h01, 16'h0003, 8'h05, 32);
        run_frame(8'h02, 16'h0003, 8'h00, 32);
        run_frame(8'h03, 16'h0000, 8'h01, 32);
        run_frame(8'h04, 16'h0000, 8'h00, 32);

        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0:       c = 8'h01;
                1:       c = 8'h02;
                2:       c = 8'h03;
                3:       c = 8'h04;
                4:       c = 8'h02;
                default: c = 8'($urandom);
            endcase
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom) : 16'($urandom_range(0, 511));
            n = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 31) : 32;
            run_frame(c, a, 8'($urandom), n);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
